// File: rtl/mac_unit_pkg.sv
// Shared types for the multiply-accumulate unit: command opcodes and FSM states.
package mac_unit_pkg;

  // Command opcodes issued by the control path in the M stage.
  typedef enum logic [2:0] {
    MAC_NOP = 3'd0,
    MAC_MUL = 3'd1,
    MAC_MAC = 3'd2,
    MAC_CLR = 3'd3,
    MAC_RDL = 3'd4,
    MAC_RDH = 3'd5
  } mac_op_t;

  // Sequencer states of the MAC unit.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    ACCUM = 2'd2
  } mac_state_t;

  // True for the opcodes that start an iterative multiply.
  function automatic logic is_mult_op(input mac_op_t op);
    return (op == MAC_MUL) || (op == MAC_MAC);
  endfunction

endpackage

// File: rtl/mac_mult_iter.sv
// Iterative radix-2^RADIX_BITS shift-add multiplier. load_i captures the
// operands and clears the partial product; each step_i retires RADIX_BITS
// multiplier bits. last_o is high while the step about to be taken is the
// final one, so the product is complete on the edge after that step.
module mac_mult_iter #(
  parameter int XLEN       = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic              step_i,
  output logic              last_o,
  output logic [2*XLEN-1:0] prod_o
);

  localparam int PW    = 2 * XLEN;
  localparam int STEPS = XLEN / RADIX_BITS;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [PW-1:0]    mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]    partial_q, partial_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The multiplicand is pre-shifted every step, so each radix digit only
  // needs a small per-bit offset instead of a growing shift amount.
  logic [PW-1:0] term [RADIX_BITS];
  logic [PW-1:0] pp_sum;

  for (genvar gi = 0; gi < RADIX_BITS; gi++) begin : g_term
    assign term[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
  end

  // Sum of the per-bit terms: multiplicand times the low radix digit.
  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      pp_sum = pp_sum + term[i];
    end
  end

  // Next-state datapath: load operands, or retire one radix digit per step.
  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    partial_d = partial_q;
    cnt_d     = cnt_q;
    if (load_i) begin
      mcand_d   = PW'(a_i);
      mplier_d  = b_i;
      partial_d = '0;
      cnt_d     = CNT_W'(STEPS - 1);
    end else if (step_i) begin
      partial_d = partial_q + pp_sum;
      mcand_d   = mcand_q << RADIX_BITS;
      mplier_d  = mplier_q >> RADIX_BITS;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      cnt_q     <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      partial_q <= partial_d;
      cnt_q     <= cnt_d;
    end
  end

  assign last_o = (cnt_q == '0);
  assign prod_o = partial_q;

endmodule

// File: rtl/mac_unit.sv
// Multi-cycle multiply-accumulate unit for the M stage. Owns the command
// sequencer and the accumulator; the multiply itself runs in mac_mult_iter.
module mac_unit
  import mac_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ACC_W      = 64,
  parameter int RADIX_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mac_write_m,
  input  mac_op_t          mac_op_m,
  input  logic [XLEN-1:0]  src_a_m,
  input  logic [XLEN-1:0]  src_b_m,
  output logic             mac_busy_o,
  output logic             mac_done_o,
  output logic [XLEN-1:0]  mac_rdata_o,
  output logic [ACC_W-1:0] acc_o
);

  mac_state_t       state_q, state_d;
  mac_op_t          op_q, op_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic              mult_load;
  logic              mult_step;
  logic              mult_last;
  logic [2*XLEN-1:0] mult_prod;

  logic accept;
  assign accept = mac_write_m && (state_q == IDLE);

  mac_mult_iter #(
    .XLEN       (XLEN),
    .RADIX_BITS (RADIX_BITS)
  ) u_mult (
    .clk    (clk),
    .rst    (rst),
    .load_i (mult_load),
    .a_i    (src_a_m),
    .b_i    (src_b_m),
    .step_i (mult_step),
    .last_o (mult_last),
    .prod_o (mult_prod)
  );

  // Sequencer: accept commands in IDLE, step the multiplier, then fold the
  // product into the accumulator. busy/done are derived from the next state
  // so both outputs come straight from flops.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    mult_load = 1'b0;
    mult_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mult_op(mac_op_m)) begin
            mult_load = 1'b1;
            op_d      = mac_op_m;
            state_d   = MULT;
          end else if (mac_op_m == MAC_CLR) begin
            acc_d = '0;
          end
        end
      end
      MULT: begin
        mult_step = 1'b1;
        if (mult_last) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d   = ((op_q == MAC_MAC) ? acc_q : '0) + ACC_W'(mult_prod);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == ACCUM);
  end

  // State, accumulator and status flops; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= MAC_NOP;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Writeback read port: only meaningful while idle, so a read held behind a
  // multiply sees zero until the result is final.
  always_comb begin
    mac_rdata_o = '0;
    if (state_q == IDLE) begin
      if (mac_op_m == MAC_RDL) begin
        mac_rdata_o = acc_q[XLEN-1:0];
      end else if (mac_op_m == MAC_RDH) begin
        mac_rdata_o = acc_q[2*XLEN-1:XLEN];
      end
    end
  end

  assign mac_busy_o = busy_q;
  assign mac_done_o = done_q;
  assign acc_o      = acc_q;

endmodule

// File: tb/tb_mac_unit.sv
// Scoreboard bench for mac_unit: expected accumulator values are queued when
// a MUL/MAC is accepted and compared when mac_done_o pulses.
module tb_mac_unit;
  import mac_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        mac_write_m;
  mac_op_t     mac_op_m;
  logic [31:0] src_a_m;
  logic [31:0] src_b_m;
  logic        mac_busy_o;
  logic        mac_done_o;
  logic [31:0] mac_rdata_o;
  logic [63:0] acc_o;

  mac_unit dut (
    .clk         (clk),
    .rst         (rst),
    .mac_write_m (mac_write_m),
    .mac_op_m    (mac_op_m),
    .src_a_m     (src_a_m),
    .src_b_m     (src_b_m),
    .mac_busy_o  (mac_busy_o),
    .mac_done_o  (mac_done_o),
    .mac_rdata_o (mac_rdata_o),
    .acc_o       (acc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic [63:0] model_acc = '0;
  logic [63:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s 0x%0h", tag, got);
    end
  endtask

  // Scoreboard consumer: every done pulse retires one queued expectation.
  always @(negedge clk) begin
    if (rst && mac_done_o) begin
      done_cnt++;
      chk("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        chk("done_acc", acc_o, exp_q.pop_front());
      end
    end
  end

  // Present a command from a negedge and hold it until the unit is idle;
  // returns at the negedge following the accepting edge.
  task automatic issue(input mac_op_t op, input logic [31:0] a, input logic [31:0] b);
    int waited;
    waited = 0;
    mac_write_m = 1'b1;
    mac_op_m    = op;
    src_a_m     = a;
    src_b_m     = b;
    while (mac_busy_o && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_in_time", 64'(waited < 100), 64'd1);
    case (op)
      MAC_MUL: begin
        model_acc = {32'd0, a} * {32'd0, b};
        exp_q.push_back(model_acc);
      end
      MAC_MAC: begin
        model_acc = model_acc + {32'd0, a} * {32'd0, b};
        exp_q.push_back(model_acc);
      end
      MAC_CLR: model_acc = '0;
      default: ;
    endcase
    @(posedge clk);
    #1;
    mac_write_m = 1'b0;
    mac_op_m    = MAC_NOP;
    @(negedge clk);
  endtask

  // Wait (bounded) until every queued expectation has been retired.
  task automatic wait_done();
    int waited;
    waited = 0;
    while (exp_q.size() > 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("done_in_time", 64'(exp_q.size() == 0), 64'd1);
  endtask

  task automatic read_chk(input string tag, input mac_op_t op, input logic [31:0] exp);
    mac_op_m = op;
    #1;
    chk(tag, 64'(mac_rdata_o), 64'(exp));
    mac_op_m = MAC_NOP;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    int done_before;

    // Reset held for two cycles with random stimulus, including a MUL.
    rst         = 1'b0;
    mac_write_m = 1'b1;
    mac_op_m    = MAC_MUL;
    src_a_m     = $urandom;
    src_b_m     = $urandom;
    @(negedge clk);
    src_a_m = $urandom;
    src_b_m = $urandom;
    @(negedge clk);
    chk("rst_acc", acc_o, 64'd0);
    chk("rst_busy", 64'(mac_busy_o), 64'd0);
    chk("rst_done", 64'(mac_done_o), 64'd0);
    @(negedge clk);
    chk("rst_no_accept_busy", 64'(mac_busy_o), 64'd0);
    mac_write_m = 1'b0;
    mac_op_m    = MAC_NOP;
    rst         = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 64'(mac_busy_o), 64'd0);

    // MUL 3*5: busy for exactly 17 cycles, single done pulse.
    done_before = done_cnt;
    issue(MAC_MUL, 32'd3, 32'd5);
    busy_cycles = 0;
    while (mac_busy_o && busy_cycles < 100) begin
      busy_cycles++;
      @(negedge clk);
    end
    chk("mul_busy_cycles", 64'(busy_cycles), 64'd17);
    chk("mul_done_with_idle", 64'(mac_done_o), 64'd1);
    repeat (3) @(negedge clk);
    chk("mul_one_done", 64'(done_cnt - done_before), 64'd1);
    chk("mul_acc", acc_o, 64'h0000_0000_0000_000F);
    read_chk("mul_rdl", MAC_RDL, 32'h0000_000F);
    read_chk("mul_rdh", MAC_RDH, 32'h0000_0000);

    // Max operands, with RDH presented while busy.
    issue(MAC_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mac_op_m = MAC_RDH;
    busy_cycles = 0;
    while (mac_busy_o && busy_cycles < 100) begin
      #1;
      chk("rdh_while_busy", 64'(mac_rdata_o), 64'd0);
      busy_cycles++;
      @(negedge clk);
    end
    #1;
    chk("rdh_after_idle", 64'(mac_rdata_o), 64'hFFFF_FFFE);
    mac_op_m = MAC_NOP;
    wait_done();
    chk("max_mul_acc", acc_o, 64'hFFFF_FFFE_0000_0001);
    issue(MAC_MAC, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    chk("max_mac_wrap", acc_o, 64'hFFFF_FFFC_0000_0002);
    read_chk("wrap_rdh", MAC_RDH, 32'hFFFF_FFFC);
    read_chk("wrap_rdl", MAC_RDL, 32'h0000_0002);

    // Back-to-back: MAC held while the MUL is busy.
    done_before = done_cnt;
    issue(MAC_MUL, 32'd3, 32'd5);
    issue(MAC_MAC, 32'd2, 32'd7);
    wait_done();
    repeat (3) @(negedge clk);
    chk("b2b_two_dones", 64'(done_cnt - done_before), 64'd2);
    chk("b2b_acc", acc_o, 64'h1D);

    // Reset in the middle of MUL 9*9.
    issue(MAC_MUL, 32'd9, 32'd9);
    repeat (7) @(negedge clk);
    done_before = done_cnt;
    rst = 1'b0;
    exp_q.delete();
    model_acc = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_acc", acc_o, 64'd0);
    chk("midrst_busy", 64'(mac_busy_o), 64'd0);
    repeat (20) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt - done_before), 64'd0);
    chk("midrst_acc_hold", acc_o, 64'd0);
    issue(MAC_MUL, 32'd2, 32'd2);
    wait_done();
    chk("after_rst_mul", acc_o, 64'd4);

    // CLR right after a result: acc clears on the accepting edge, no busy.
    issue(MAC_CLR, 32'd0, 32'd0);
    chk("clr_acc", acc_o, model_acc);
    chk("clr_busy", 64'(mac_busy_o), 64'd0);
    read_chk("clr_rdl", MAC_RDL, 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_unit.md
Name: mac_unit

Overview:
- Multi-cycle multiply-accumulate execution unit. Sits at the memory stage of the pipelined RV32I core.
- Consumes MAC commands issued by the control path (mac_op_m, mac_write_m) with operands forwarded from the datapath.
- Iterative shift-add multiplier feeding a 64-bit accumulator.
- Raises a busy/stall request toward the hazard unit while a multiply is in flight.
- Returns accumulator halves for register writeback.

Parameters:
- XLEN, 32: operand and read-data width.
- ACC_W, 64: accumulator width; must be >= 2*XLEN.
- RADIX_BITS, 2: multiplier bits retired per cycle. Legal values 1, 2, 4; must divide XLEN.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-low reset
- mac_write_m  input  1  command strobe from control path, M stage
- mac_op_m  input  mac_op_t  command opcode, M stage
- src_a_m  input  XLEN  operand A (multiplicand)
- src_b_m  input  XLEN  operand B (multiplier)
- mac_busy_o  output  1  stall request to hazard unit
- mac_done_o  output  1  one-cycle pulse: accumulator updated by MUL/MAC
- mac_rdata_o  output  XLEN  selected accumulator half for writeback
- acc_o  output  ACC_W  accumulator value, debug/observe

Behaviour:
- Reset:
  - One clock only; rst is synchronous, active-low. rst=0 at a rising clk edge forces the reset state.
  - Reset state: state=IDLE, acc=0, mac_busy_o=0, mac_done_o=0, internal counter/partial product=0.
  - Reset mid-operation aborts the multiply; no accumulator update, no done pulse.
- Opcodes (mac_op_t): MAC_NOP, MAC_MUL (acc = a*b), MAC_MAC (acc = acc + a*b), MAC_CLR (acc = 0), MAC_RDL (read acc[XLEN-1:0]), MAC_RDH (read acc[2*XLEN-1:XLEN]).
- Arithmetic:
  - Operands are unsigned. Product is a full 2*XLEN bits, zero-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; no saturation, no overflow flag.
- Acceptance: a command is accepted on a rising edge when mac_write_m=1 and state=IDLE.
  - A command presented while busy is ignored. The hazard unit must hold it stalled in M, and it is accepted on the first edge with state=IDLE.
  - MAC_NOP is accepted with no effect.
- States:
  - IDLE: mac_busy_o=0.
    - MUL/MAC accepted: latch multiplicand, multiplier and op; clear partial product; cnt = XLEN/RADIX_BITS-1; go to MULT.
    - CLR accepted: acc=0 on the same edge; stay IDLE.
    - RDL/RDH: no state change.
  - MULT: mac_busy_o=1.
    - Each cycle: partial += (multiplicand * multiplier[RADIX_BITS-1:0]) << shift; multiplier >>= RADIX_BITS; shift += RADIX_BITS.
    - At cnt==0 go to ACCUM; otherwise cnt decrements.
  - ACCUM: mac_busy_o=1. On exit edge: acc = (op==MAC ? acc : 0) + partial; mac_done_o=1 for the following cycle; go to IDLE.
- Latency (defaults):
  - Accepting edge E0; MULT occupies 16 cycles; ACCUM 1 cycle.
  - New acc visible after edge E17, with mac_done_o high in that same cycle and mac_busy_o low.
  - Generally XLEN/RADIX_BITS+1 cycles busy.
- mac_busy_o is registered; it is high exactly in MULT and ACCUM.
- mac_rdata_o is combinational from acc and mac_op_m:
  - RDL selects the low half; RDH selects the high half; any other op gives 0.
  - Valid only when state=IDLE; it is 0 while busy, so a read behind a multiply is stalled until the result is final.
- CLR or a read immediately after done observes the updated acc.

Decomposition:
- Package types holds mac_op_t (3-bit enum with the encodings above) and mac_state_t (IDLE, MULT, ACCUM).
- Sub-module mac_mult_iter: iterative radix-2^RADIX_BITS shift-add datapath with load/step/last handshake. The FSM and accumulator stay in mac_unit.

Test Plan:
- Reset: rst=0 for 2 cycles with random inputs -> acc_o=0, mac_busy_o=0, mac_done_o=0. Drive MUL with rst=0 -> nothing accepted.
- MUL 3*5 -> mac_busy_o high exactly 17 cycles; then acc_o=0x000000000000000F, mac_done_o pulses once. RDL gives 0x0000000F, RDH gives 0.
- MUL 0xFFFFFFFF*0xFFFFFFFF -> acc=0xFFFFFFFE00000001. MAC same operands -> acc wraps to 0xFFFFFFFC00000002. RDH gives 0xFFFFFFFC, RDL gives 0x00000002.
- Back-to-back: MAC 2*7 held with mac_write_m=1 while busy from MUL 3*5 -> second command accepted on the first idle edge; final acc=0x1D; exactly two done pulses.
- CLR after a result -> acc=0 the next cycle, no busy. RDH while busy -> mac_rdata_o=0 until state=IDLE.
- Reset mid-MULT (cycle 8 of MUL 9*9, prior acc=0x1D) -> state IDLE, acc=0, no done pulse; a new MUL 2*2 then gives acc=4.
